dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// Multi-cycle data-memory responder: target side of the core's load/store port.
// Accepts one request per valid/ready handshake, holds it for WAIT_CYCLES, commits
// byte-masked writes, returns read data / completion with a valid/ready response.
// Replaces the zero-latency data memory so the core can be tested against wait states.
// PARAMETERS
// DEPTH_WORDS  256  number of 32-bit words in the internal array (power of 2)
// WAIT_CYCLES  2    cycles spent in WAIT after accept; 0 = skip WAIT (0..15)
// BASE_ADDR    0    byte address of word 0; must be 4-byte aligned
// PORTS
// clock       in   1   rising-edge clock
// reset       in   1   asynchronous, active-low reset
// req_valid   in   1   request present
// req_ready   out  1   responder can accept a request
// req_write   in   1   1 = store, 0 = load
// req_addr    in   32  byte address
// req_wdata   in   32  store data
// req_be      in   4   byte enables; be[i] covers wdata[8i+7:8i]
// resp_valid  out  1   response present
// resp_ready  in   1   core accepts response
// resp_rdata  out  32  load data; 0 for stores and errors
// resp_err    out  1   misaligned or out-of-range access
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0,
//   resp_err=0, wait counter=0. Memory array is NOT cleared.
// - FSM: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: req_ready=1. On req_valid&req_ready, latch write/addr/wdata/be;
//     next state WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0). Load counter.
//   WAIT: req_ready=0. Counter decrements each cycle; leave to RESP after
//     exactly WAIT_CYCLES cycles in WAIT.
//   RESP: req_ready=0, resp_valid=1. Outputs stable until resp_valid&resp_ready;
//     then IDLE on the next edge.
// - Latency: accept edge to resp_valid rising = WAIT_CYCLES+1 cycles.
//   Minimum request spacing = WAIT_CYCLES+2 cycles. No back-to-back accept in RESP.
// - Error check on the latched request: err = (addr[1:0]!=0) |
//   ((addr-BASE_ADDR) >= DEPTH_WORDS*4), with 32-bit unsigned subtract, so
//   addr < BASE_ADDR wraps and is out of range.
// - Word index = (addr-BASE_ADDR)>>2, taking log2(DEPTH_WORDS) bits.
// - Store: on the edge entering RESP, if !err, write bytes where be[i]=1.
//   Other bytes keep their old values. be=0 is legal and leaves memory unchanged.
//   resp_rdata=0.
// - Load: on the edge entering RESP, resp_rdata = full word at index.
//   be is ignored; byte selection is done by the core.
// - Error: no memory change, resp_rdata=0, resp_err=1.
// - req_* inputs are ignored outside IDLE. Changing them after accept has no effect.
// - resp_ready while resp_valid=0 is ignored.
// - Reset mid-operation: the pending request is dropped. A write not yet committed
//   (still in WAIT) never reaches memory. No response is issued.
// - The counter is wide enough for WAIT_CYCLES and does not wrap.
// TESTING
// 1 W=2: store addr 0x10, wdata 0xDEADBEEF, be=F; then load 0x10 -> rdata 0xDEADBEEF,
//   err=0, resp_valid 3 cycles after each accept.
// 2 Byte mask: word 0x10=0xDEADBEEF; store wdata 0x11223344, be=0101 ->
//   load gives 0xDE22BE44.
// 3 Errors: load 0x12 -> err=1, rdata 0. Store 0x400 (DEPTH 256) -> err=1,
//   and word 0 is unchanged on reload.
// 4 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, rdata, err stable;
//   req_ready=0 throughout; a new req_valid is not accepted until after the handshake.
// 5 W=0: accept at edge N -> resp_valid at edge N+1. With resp_ready held 1,
//   next accept at N+2.
// 6 Reset in WAIT of a store to 0x20 (old 0x0) -> outputs take reset values
//   immediately; later load 0x20 returns 0x0.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store request per handshake,
// waits WAIT_CYCLES, commits byte-masked stores and returns data through a valid/ready response.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT     = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t             state, state_next;
  logic [3:0]         cnt, cnt_next;
  logic               accept, commit;

  logic               lat_write;
  logic [31:0]        lat_addr, lat_wdata;
  logic [3:0]         lat_be;

  logic               cur_write;
  logic [31:0]        cur_addr, cur_wdata;
  logic [3:0]         cur_be;
  logic [31:0]        offset;
  logic               err;
  logic [IDX_W-1:0]   idx;

  logic [31:0]        mem [DEPTH_WORDS];

  // With WAIT_CYCLES=0 the commit happens on the accept edge itself, so the
  // request is taken straight from the inputs while IDLE, otherwise from the latch.
  always_comb begin
    cur_write = lat_write;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    cur_be    = lat_be;
    if (state == IDLE) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end
  end

  // Unsigned subtract makes addresses below BASE_ADDR wrap to a huge offset.
  assign offset = cur_addr - BASE_ADDR;
  assign err    = (cur_addr[1:0] != 2'b00) || ({1'b0, offset} >= LIMIT);
  assign idx    = offset[IDX_W+1:2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_next = RESP;
          commit     = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_write <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_be    <= 4'h0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (commit) begin
      resp_err   <= err;
      resp_rdata <= (!err && !cur_write) ? mem[idx] : 32'h0;
    end
  end

  // The array is deliberately left out of reset so contents survive a core reset.
  always_ff @(posedge clock) begin
    if (commit && cur_write && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_be[b]) mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance driven from a vector table
// plus stall/reset sequences, and a WAIT_CYCLES=0 instance for back-to-back spacing.
module tb_dmem_responder;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid_z = 1'b0, req_write_z = 1'b0, resp_ready_z = 1'b0;
  logic [31:0] req_addr_z = 32'h0, req_wdata_z = 32'h0;
  logic [3:0]  req_be_z = 4'h0;
  logic        req_ready_z, resp_valid_z, resp_err_z;
  logic [31:0] resp_rdata_z;

  int checks = 0;
  int errors = 0;

  vec_t vecs [12];

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_z (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_be(req_be_z),
    .resp_valid(resp_valid_z), .resp_ready(resp_ready_z),
    .resp_rdata(resp_rdata_z), .resp_err(resp_err_z)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one request into the WAIT_CYCLES=2 instance and checks latency and payload.
  task automatic apply_stimulus(input vec_t v, input string tag);
    int lat;
    @(negedge clock);
    check_output({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_be    = v.be;
    @(posedge clock);
    lat = 0;
    do begin
      @(negedge clock);
      req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 16);
    check_output({tag, " latency"}, 32'(lat), 32'd3);
    check_output({tag, " rdata"}, resp_rdata, v.exp_rdata);
    check_output({tag, " err"}, 32'(resp_err), 32'(v.exp_err));
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    check_output({tag, " resp_valid drop"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic rdy [10];
    logic vld [10];
    logic [31:0] rd [10];

    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,       32'h11223344, 4'h5, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,       32'h0,        4'hF, 32'hDE22BE44, 1'b0};
    vecs[4]  = '{1'b1, 32'h0,        32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h12,       32'h0,        4'hF, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h400,      32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vecs[8]  = '{1'b1, 32'h20,       32'h0,        4'hF, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 32'h20,       32'hAABBCCDD, 4'h0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h20,       32'h0,        4'hF, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'hF, 32'h0,        1'b1};

    $display("[TB] starting dmem_responder bench");
    @(negedge clock);
    @(negedge clock);
    check_output("reset req_ready", 32'(req_ready), 32'd1);
    check_output("reset resp_valid", 32'(resp_valid), 32'd0);
    check_output("reset rdata", resp_rdata, 32'h0);
    check_output("reset err", 32'(resp_err), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Response stall: outputs must hold while a second request waits outside.
    @(negedge clock);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h10;
    @(posedge clock);
    lat = 0;
    do begin
      @(negedge clock);
      req_addr = 32'h0;
      lat++;
    end while (!resp_valid && lat < 16);
    check_output("stall latency", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      check_output($sformatf("stall%0d resp_valid", c), 32'(resp_valid), 32'd1);
      check_output($sformatf("stall%0d rdata", c), resp_rdata, 32'hDE22BE44);
      check_output($sformatf("stall%0d err", c), 32'(resp_err), 32'd0);
      check_output($sformatf("stall%0d req_ready", c), 32'(req_ready), 32'd0);
      @(negedge clock);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    check_output("post-stall resp_valid", 32'(resp_valid), 32'd0);
    check_output("post-stall req_ready", 32'(req_ready), 32'd1);
    @(posedge clock);
    lat = 0;
    do begin
      @(negedge clock);
      req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 16);
    check_output("queued latency", 32'(lat), 32'd3);
    check_output("queued rdata", resp_rdata, 32'hCAFEF00D);
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;

    // Reset while a store sits in WAIT: outputs clear at once, store is dropped.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_output("midreset req_ready", 32'(req_ready), 32'd1);
    check_output("midreset resp_valid", 32'(resp_valid), 32'd0);
    check_output("midreset rdata", resp_rdata, 32'h0);
    check_output("midreset err", 32'(resp_err), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    apply_stimulus('{1'b0, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0}, "after-reset load");

    // Zero-wait instance: stores then a load, request and response held active.
    resp_ready_z = 1'b1;
    req_valid_z  = 1'b1;
    req_write_z  = 1'b1;
    req_addr_z   = 32'h40;
    req_wdata_z  = 32'h00000055;
    req_be_z     = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (c == 4) req_write_z = 1'b0;
      rdy[c] = req_ready_z;
      vld[c] = resp_valid_z;
      rd[c]  = resp_rdata_z;
    end
    req_valid_z  = 1'b0;
    resp_ready_z = 1'b0;
    for (int c = 1; c < 10; c++) begin
      check_output($sformatf("w0 req_ready[%0d]", c), 32'(rdy[c]), 32'(c % 2 == 1));
      check_output($sformatf("w0 resp_valid[%0d]", c), 32'(vld[c]), 32'(c % 2 == 0));
    end
    check_output("w0 store rdata", rd[4], 32'h0);
    check_output("w0 load rdata", rd[6], 32'h00000055);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
